// File: rtl/ht_stream_scheduler_pkg.sv
// ht_stream_scheduler_pkg
// Shared constants and the sequencer state encoding for the Hilbert
// transform frame scheduler. The LENGTH/DATA_WIDTH defaults are shared with
// the transform and the coefficient-setup blocks, so change them here only.
// Ports: none (package).
package ht_stream_scheduler_pkg;

  localparam int HT_LENGTH     = 27;
  localparam int HT_DATA_WIDTH = 18;
  localparam int HT_CNT_WIDTH  = 16;
  localparam int HT_OUT_LAT    = 4;

  // Cycles spent in STOP after the stop-flag cycle, giving the transform
  // time to fall back into its own idle state.
  localparam int HT_STOP_HOLD  = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } SchedState;

endpackage

// File: rtl/ht_valid_delay.sv
// ht_valid_delay
// DEPTH-stage 1-bit shift register that delays the "sample slot driven"
// strobe so it lines up with the transform's Re/Im outputs.
// Ports:
//   clock  - clock
//   resetN - asynchronous active-low reset, empties the line
//   clear  - synchronous clear, empties the line on the next edge
//   din    - strobe in
//   dout   - strobe delayed by DEPTH cycles
module ht_valid_delay
  import ht_stream_scheduler_pkg::*;
#(
  parameter int DEPTH = HT_OUT_LAT
) (
  input  logic clock,
  input  logic resetN,
  input  logic clear,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] stages;

  // Plain shift line; stage 0 takes the new strobe and every other stage
  // takes its neighbour. Written as a loop so DEPTH=1 also elaborates.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      stages <= '0;
    end else if (clear) begin
      stages <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/ht_stream_scheduler.sv
// ht_stream_scheduler
// Frame-level sequencer in front of the 27-tap FIR Hilbert transform. On an
// accepted start it enables the transform, waits out the coefficient load,
// streams frameLength samples (zero-filling missing ones), flushes the FIR
// with LENGTH zeros, pulses the stop flag and reports frame completion.
// Ports:
//   clock, resetN        - clock, asynchronous active-low reset
//   startFrame           - one-cycle start request (honoured in IDLE only)
//   abortFrame           - ends the frame early from ARM/STREAM/FLUSH
//   frameLength          - samples per frame, latched on an accepted start
//   sampleValid/sampleIn - sample source
//   sampleReady          - sampleIn is consumed this cycle
//   htEnable/htStopFlag/htDataIn - transform control and data
//   outValid             - transform outputs this cycle belong to the frame
//   busy, frameDone, underrun - status
module ht_stream_scheduler
  import ht_stream_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = HT_DATA_WIDTH,
  parameter int LENGTH     = HT_LENGTH,
  parameter int COEFF_WAIT = LENGTH + 2,
  parameter int OUT_LAT    = HT_OUT_LAT,
  parameter int CNT_WIDTH  = HT_CNT_WIDTH
) (
  input  logic                         clock,
  input  logic                         resetN,
  input  logic                         startFrame,
  input  logic                         abortFrame,
  input  logic [CNT_WIDTH-1:0]         frameLength,
  input  logic                         sampleValid,
  input  logic signed [DATA_WIDTH-1:0] sampleIn,
  output logic                         sampleReady,
  output logic                         htEnable,
  output logic                         htStopFlag,
  output logic signed [DATA_WIDTH-1:0] htDataIn,
  output logic                         outValid,
  output logic                         busy,
  output logic                         frameDone,
  output logic                         underrun
);

  localparam logic [CNT_WIDTH-1:0] ARM_LAST   = CNT_WIDTH'(COEFF_WAIT - 1);
  localparam logic [CNT_WIDTH-1:0] FLUSH_LAST = CNT_WIDTH'(LENGTH - 1);
  localparam logic [CNT_WIDTH-1:0] STOP_LAST  = CNT_WIDTH'(HT_STOP_HOLD);
  localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);

  SchedState            state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] lenReg;
  logic                 slotStrobe;
  logic                 abortNow;
  logic                 stopClear;

  // Abort only means something while the transform is being fed; in IDLE,
  // STOP and DONE the frame is already idle or on its way out.
  assign abortNow    = abortFrame && ((state == ARM) || (state == STREAM) || (state == FLUSH));
  // Ready follows the state directly so an abort withdraws it in the same
  // cycle instead of swallowing one more sample.
  assign sampleReady = (state == STREAM) && !abortFrame;
  assign busy        = (state != IDLE);
  assign stopClear   = (state == STOP);

  // Main sequencer. Pulse-type outputs (stop flag, frame done, slot strobe)
  // and the data bus default to zero every cycle and are only raised by the
  // state that owns them. A single counter times ARM, STREAM, FLUSH and
  // STOP; it is reset on every state change. The transform cannot stall, so
  // a missing sample still uses up a slot and just marks underrun.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      cnt        <= '0;
      lenReg     <= '0;
      htEnable   <= 1'b0;
      htStopFlag <= 1'b0;
      htDataIn   <= '0;
      slotStrobe <= 1'b0;
      frameDone  <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      htStopFlag <= 1'b0;
      frameDone  <= 1'b0;
      slotStrobe <= 1'b0;
      htDataIn   <= '0;
      if (abortNow) begin
        state      <= STOP;
        cnt        <= '0;
        htStopFlag <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (startFrame && (frameLength != '0)) begin
              lenReg   <= frameLength;
              underrun <= 1'b0;
              htEnable <= 1'b1;
              cnt      <= '0;
              state    <= ARM;
            end
          end
          ARM: begin
            if (cnt == ARM_LAST) begin
              cnt   <= '0;
              state <= STREAM;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          STREAM: begin
            slotStrobe <= 1'b1;
            if (sampleValid) begin
              htDataIn <= sampleIn;
            end else begin
              underrun <= 1'b1;
            end
            if (cnt == lenReg - ONE) begin
              cnt   <= '0;
              state <= FLUSH;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          FLUSH: begin
            if (cnt == FLUSH_LAST) begin
              cnt        <= '0;
              htStopFlag <= 1'b1;
              state      <= STOP;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          STOP: begin
            htEnable <= 1'b0;
            if (cnt == STOP_LAST) begin
              cnt       <= '0;
              frameDone <= 1'b1;
              state     <= DONE;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Valid tag for the transform outputs: the slot strobe delayed by the
  // transform latency, emptied in STOP so an aborted frame leaves nothing
  // behind for the next one.
  ht_valid_delay #(
    .DEPTH(OUT_LAT)
  ) validDelay (
    .clock  (clock),
    .resetN (resetN),
    .clear  (stopClear),
    .din    (slotStrobe),
    .dout   (outValid)
  );

endmodule
